psum_ofifo: RTL and testbench
=============================

# psum_ofifo

Output FIFO between the MAC array and the 8-lane SFP stage. It accepts one psum per column lane whenever that lane produces one; lanes may write out of step with each other. Once every lane holds at least one entry, it releases one aligned col-wide vector. The vector is laid out exactly as the SFP `sfp_in` bus expects.

## Interface
- `col`, 8, number of lanes (psum columns)
- `bw`, 8, activation/weight width
- `bw_psum`, 2*bw+4 (20), width of one psum
- `depth`, 16, entries per lane; power of two, ≥2
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately, independent of `clk`
- `wr`  in  col  per-lane write strobe; bit i writes lane i
- `in`  in  col*bw_psum  write data; lane i = bits [(i+1)*bw_psum-1 : i*bw_psum]
- `rd`  in  1  pop one entry from every lane simultaneously
- `out`  out  col*bw_psum  registered popped vector, same lane slicing as `in`; reset 0
- `o_valid`  out  1  every lane non-empty; reset 0
- `o_full`  out  1  any lane holds `depth` entries; reset 0
- `o_ready`  out  1  ~`o_full`; reset 1
- `err_ovf`  out  1  sticky: a write was dropped; reset 0
- `err_udf`  out  1  sticky: `rd` arrived while `o_valid`=0; reset 0

## Operation
**Storage**
- Each lane has its own `depth`-entry storage.
- Each lane has its own write pointer of log2(depth)+1 bits.
- All lanes share one read pointer of the same width.
- Lane occupancy = wr_ptr[i] − rd_ptr, modulo 2^(log2(depth)+1).
- Empty: occupancy 0. Full: occupancy `depth`.
- Pointers wrap naturally. Array index = pointer[log2(depth)-1:0].

**Status flags**
- `o_valid`, `o_full` and `o_ready` are combinational from the current pointers, so they reflect state after the last edge.

**Read**
- Read accepted = `rd` & `o_valid`.
- On an accepted read:
  - `out` loads the head entry of every lane.
  - rd_ptr increments.
- `rd` with `o_valid`=0:
  - Ignored: `out` and pointers are unchanged.
  - `err_udf` is set.
- `out` holds its value between accepted reads.

**Write**
- Write accepted on lane i = `wr[i]` & (lane i not full | read accepted this cycle).
- On an accepted write: store `in` lane i slice at wr_ptr[i], then increment wr_ptr[i].
- `wr[i]` on a full lane with no accepted read:
  - The data is dropped and wr_ptr[i] is unchanged.
  - `err_ovf` is set.
  - Other lanes written in the same cycle are unaffected.

**Simultaneous events**
- Full and empty tests use the state before the edge.
- A write to an empty lane cannot be popped in the same cycle.
- Full lane + `wr` + accepted `rd`: both occur and occupancy stays `depth`.

**Error flags**
- `err_ovf` and `err_udf` are cleared only by `reset`.

**Data**
- Data passes through unmodified: no arithmetic, no sign handling.
- Lane order is preserved.

## Timing
- Write-to-valid latency is 1.
  - If the last non-empty lane is written at edge N, `o_valid` is 1 from edge N to edge N+1.
  - `rd` may be asserted in that cycle.
- Read latency is 1.
  - An accepted `rd` in the cycle ending at edge M presents the data on `out` after edge M.
  - `o_valid` updates after edge M.
- Sustained throughput: one vector per cycle while every lane is written every cycle and `rd` is held high.
- `reset` assertion, including mid-stream:
  - All pointers clear immediately; stored data is discarded.
  - `out`=0, `o_valid`=0, `o_full`=0, `o_ready`=1, both error flags 0, all without waiting for a clock edge.
  - Storage array contents need not be cleared.
- After `reset` deassertion, the first edge may accept writes.
- `wr`/`rd` on the edge coinciding with deassertion are not required to be accepted.

## Test plan
1. **Reset values:** assert `reset` asynchronously with no clock running → `out`=0, `o_valid`=0, `o_full`=0, `o_ready`=1, `err_ovf`=0, `err_udf`=0.
2. **Skewed lanes:**
   - Stimulus: write lane i at cycle i with value 100+i, i=0..7.
   - Required: `o_valid` stays 0 until the edge after the lane 7 write, then goes to 1.
   - Then `rd` for one cycle → `out` lanes 0..7 = 100..107 and `o_valid` returns to 0.
3. **Fill/overflow:**
   - Stimulus: write 16 vectors (value 16*k+i on lane i) with `rd`=0.
   - Required: `o_full`=1, `o_ready`=0.
   - Then write lane 3 with 999 → dropped, `err_ovf`=1.
   - Then 16 reads → vectors k=0..15 appear in order; 999 never appears.
4. **Underflow:**
   - Stimulus: write lanes 0–6 only, then assert `rd`.
   - Required: `out` unchanged, `err_udf`=1, and subsequently writing lane 7 then `rd` returns the lanes 0–6 data plus the lane 7 data.
5. **Full with concurrent read/write:** fill all lanes, then assert `wr`=8'hFF and `rd` for 5 cycles → no `err_ovf`, `o_full` stays 1, and the 21 vectors read back in order.
6. **Wrap-around and mid-stream reset:**
   - Stimulus: 40 interleaved push/pop vectors with random gaps.
   - Required: every `out` matches the scoreboard.
   - Then, with 5 entries held, pulse `reset` between clock edges → outputs reach reset values immediately and `o_valid`=0 after release.

Source files
------------

// File: rtl/psum_ofifo.sv
// Per-lane psum FIFO that releases one aligned col-wide vector once every
// lane holds data; the output bus matches the SFP input slicing.
module psum_ofifo #(
  parameter int col     = 8,
  parameter int bw      = 8,
  parameter int bw_psum = 2*bw+4,
  parameter int depth   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [col-1:0]           wr,
  input  logic [col*bw_psum-1:0]   in,
  input  logic                     rd,
  output logic [col*bw_psum-1:0]   out,
  output logic                     o_valid,
  output logic                     o_full,
  output logic                     o_ready,
  output logic                     err_ovf,
  output logic                     err_udf
);

  localparam int aw = $clog2(depth);
  localparam logic [aw:0] full_lvl = (aw+1)'(depth);
  localparam logic [aw:0] one = (aw+1)'(1);

  logic [aw:0]        wp [col];
  logic [aw:0]        rp;
  logic [bw_psum-1:0] mem [col][depth];
  logic [col-1:0]     empty;
  logic [col-1:0]     full;
  logic [col-1:0]     wr_ok;
  logic               rd_ok;

  // occupancy is the modular pointer distance, so wrap needs no special case
  always_comb begin
    empty = '0;
    full  = '0;
    for (int i = 0; i < col; i++) begin
      empty[i] = (wp[i] - rp) == '0;
      full[i]  = (wp[i] - rp) == full_lvl;
    end
  end

  assign o_valid = ~|empty;
  assign o_full  = |full;
  assign o_ready = ~o_full;
  assign rd_ok   = rd & o_valid;
  assign wr_ok   = wr & (~full | {col{rd_ok}});

  // a full lane written while popping lands in the slot being read;
  // the pop still sees the old entry
  always_ff @(posedge clk) begin
    for (int i = 0; i < col; i++) begin
      if (wr_ok[i])
        mem[i][wp[i][aw-1:0]] <= in[i*bw_psum +: bw_psum];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < col; i++)
        wp[i] <= '0;
      rp      <= '0;
      out     <= '0;
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
    end else begin
      for (int i = 0; i < col; i++) begin
        if (wr_ok[i])
          wp[i] <= wp[i] + one;
      end
      if (rd_ok) begin
        rp <= rp + one;
        for (int i = 0; i < col; i++)
          out[i*bw_psum +: bw_psum] <= mem[i][rp[aw-1:0]];
      end
      if (|(wr & ~wr_ok))
        err_ovf <= 1'b1;
      if (rd & ~o_valid)
        err_udf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_psum_ofifo.sv
// Randomized scoreboard bench for psum_ofifo against per-lane queue model.
module tb_psum_ofifo;

  localparam int COL = 8;
  localparam int PW  = 20;
  localparam int DEP = 16;
  localparam int VW  = COL*PW;

  logic          clk = 1'b0;
  logic          clk_en = 1'b0;
  logic          reset;
  logic [COL-1:0] wr;
  logic [VW-1:0] in_d;
  logic          rd;
  logic [VW-1:0] out;
  logic          o_valid, o_full, o_ready, err_ovf, err_udf;

  int total = 0;
  int bad   = 0;

  logic [PW-1:0] lq [COL][$];
  logic [VW-1:0] exp_q [$];
  logic [VW-1:0] m_out;
  bit            m_ovf, m_udf;
  int            m_reads;

  psum_ofifo #(.col(COL), .bw(8), .bw_psum(PW), .depth(DEP)) dut (
    .clk(clk), .reset(reset), .wr(wr), .in(in_d), .rd(rd),
    .out(out), .o_valid(o_valid), .o_full(o_full), .o_ready(o_ready),
    .err_ovf(err_ovf), .err_udf(err_udf)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic chk(input string name, input logic [VW-1:0] act,
                     input logic [VW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // monitor: every accepted pop must present the next scoreboard vector
  always @(posedge clk) begin
    if (!reset && rd && o_valid) begin
      #1;
      if (exp_q.size() == 0) chk("pop_unexpected", 1, 0);
      else chk("out_vec", out, exp_q.pop_front());
    end
  end

  task automatic model_clear();
    for (int i = 0; i < COL; i++) lq[i].delete();
    exp_q.delete();
    m_out = '0;
    m_ovf = 0;
    m_udf = 0;
  endtask

  task automatic step(input logic [COL-1:0] w, input logic [VW-1:0] d,
                      input logic r);
    bit v, f, ra;
    bit fp [COL];
    logic [VW-1:0] vec;
    @(negedge clk);
    wr = w; in_d = d; rd = r;
    v = 1; f = 0;
    for (int i = 0; i < COL; i++) begin
      if (lq[i].size() == 0) v = 0;
      fp[i] = (lq[i].size() == DEP);
      if (fp[i]) f = 1;
    end
    chk("o_valid", o_valid, v);
    chk("o_full", o_full, f);
    chk("o_ready", o_ready, !f);
    chk("err_ovf", err_ovf, m_ovf);
    chk("err_udf", err_udf, m_udf);
    chk("out_hold", out, m_out);
    ra = r && v;
    if (r && !v) m_udf = 1;
    if (ra) begin
      for (int i = 0; i < COL; i++) vec[i*PW +: PW] = lq[i].pop_front();
      exp_q.push_back(vec);
      m_out = vec;
      m_reads++;
    end
    for (int i = 0; i < COL; i++)
      if (w[i]) begin
        if (!fp[i] || ra) lq[i].push_back(d[i*PW +: PW]);
        else m_ovf = 1;
      end
  endtask

  function automatic logic [VW-1:0] rnd_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < COL; i++) v[i*PW +: PW] = PW'($urandom);
    return v;
  endfunction

  initial begin
    logic [VW-1:0] d;
    logic [COL-1:0] w;
    wr = '0; rd = 0; in_d = '0; reset = 0;
    model_clear();
    m_reads = 0;

    // reset with no clock running
    #1 reset = 1;
    #2;
    chk("rst_out", out, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_full", o_full, 0);
    chk("rst_ready", o_ready, 1);
    chk("rst_ovf", err_ovf, 0);
    chk("rst_udf", err_udf, 0);
    #1 reset = 0;
    #2 clk_en = 1;

    // skewed lanes
    for (int i = 0; i < COL; i++) begin
      d = '0;
      d[i*PW +: PW] = PW'(100 + i);
      step(COL'(1) << i, d, 0);
    end
    step('0, '0, 1);
    step('0, '0, 0);
    chk("skew_lane7", out[7*PW +: PW], 107);

    // fill then overflow
    for (int k = 0; k < DEP; k++) begin
      for (int i = 0; i < COL; i++) d[i*PW +: PW] = PW'(16*k + i);
      step('1, d, 0);
    end
    d = '0;
    d[3*PW +: PW] = 999;
    step(8'h08, d, 0);
    for (int k = 0; k < DEP; k++) step('0, '0, 1);
    step('0, '0, 0);
    chk("ovf_last_lane3", out[3*PW +: PW], 16*15 + 3);

    // underflow
    step(8'h7f, rnd_vec(), 0);
    step('0, '0, 1);
    step(8'h80, rnd_vec(), 0);
    step('0, '0, 1);
    step('0, '0, 0);

    // full with concurrent read/write
    for (int k = 0; k < DEP; k++) step('1, rnd_vec(), 0);
    for (int k = 0; k < 5; k++) step('1, rnd_vec(), 1);
    for (int k = 0; k < DEP; k++) step('0, '0, 1);
    step('0, '0, 0);

    // random interleave across pointer wrap
    m_reads = 0;
    for (int c = 0; c < 3000 && m_reads < 40; c++) begin
      for (int i = 0; i < COL; i++) w[i] = ($urandom_range(0, 9) < 7);
      step(w, rnd_vec(), $urandom_range(0, 2) != 0);
    end
    chk("rand_reads", (m_reads >= 40), 1);
    for (int k = 0; k < DEP + 2; k++) step('0, '0, 1);
    for (int k = 0; k < 5; k++) step('1, rnd_vec(), 0);
    step('0, '0, 0);

    // mid-stream reset between edges
    @(negedge clk);
    #2 reset = 1;
    #1;
    chk("mrst_out", out, 0);
    chk("mrst_valid", o_valid, 0);
    chk("mrst_full", o_full, 0);
    chk("mrst_ready", o_ready, 1);
    chk("mrst_ovf", err_ovf, 0);
    chk("mrst_udf", err_udf, 0);
    model_clear();
    #1 reset = 0;
    step('0, '0, 0);
    step('1, rnd_vec(), 0);
    step('0, '0, 1);
    step('0, '0, 0);
    step('0, '0, 0);
    chk("sb_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
